// File: rtl/skip_fork.sv
`default_nettype none
// ============================================================================
// Module      : skip_fork
// Description : Source-side fork for a two-input residual adder. A D x D pixel
//               stream is forwarded with one cycle of latency on the main path
//               and is also captured in a D*D-word buffer. On request, the
//               buffer is replayed in raster order on the skip path with
//               valid/ready backpressure.
// Ports       : clk            - clock, all logic on posedge
//               reset          - synchronous, active-high
//               valid_in       - pxl_in valid this cycle
//               pxl_in         - input pixel, raster order
//               replay_start   - single-cycle pulse, begin skip replay
//               skip_ready     - downstream accepts pxl_out_skip this cycle
//               pxl_out_main   - forwarded pixel (holds when no valid input)
//               valid_out_main - pxl_out_main valid
//               pxl_out_skip   - replayed pixel
//               valid_out_skip - pxl_out_skip valid
//               buf_full       - D*D words captured, awaiting replay
//               drop           - sticky: an input arrived that could not be stored
// Revision    : 1.0 - initial release
// ============================================================================
module skip_fork #(
    parameter int D          = 220,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  replay_start,
    input  logic                  skip_ready,
    output logic [DATA_WIDTH-1:0] pxl_out_main,
    output logic                  valid_out_main,
    output logic [DATA_WIDTH-1:0] pxl_out_skip,
    output logic                  valid_out_skip,
    output logic                  buf_full,
    output logic                  drop
);

    localparam int                  c_DEPTH   = D * D;
    localparam logic [ADDR_WIDTH:0] c_LAST    = (ADDR_WIDTH + 1)'(c_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] c_DEPTH_W = (ADDR_WIDTH + 1)'(c_DEPTH);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_FULL   = 2'd1,
        ST_REPLAY = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    logic [ADDR_WIDTH:0]   r_wr_cnt;     // words captured in the current frame
    logic [ADDR_WIDTH:0]   r_fetch_cnt;  // next buffer address to read
    logic [ADDR_WIDTH:0]   r_rd_cnt;     // words transferred on the skip path

    // Read stage: registered buffer output, acts as a one-word prefetch
    // slot behind the skip output register.
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic [DATA_WIDTH-1:0] r_pxl_main;
    logic                  r_valid_main;
    logic [DATA_WIDTH-1:0] r_skip_data;
    logic                  r_skip_valid;
    logic                  r_drop;

    logic                  w_wr_en;
    logic                  w_wr_last;
    logic                  w_start;
    logic                  w_replay;
    logic                  w_out_ready;
    logic                  w_xfer;
    logic                  w_xfer_last;
    logic                  w_slot_free;
    logic                  w_fetch;
    logic [ADDR_WIDTH-1:0] w_fetch_addr;

    assign w_wr_en     = !reset && (r_state == ST_FILL) && valid_in;
    assign w_wr_last   = w_wr_en && (r_wr_cnt == c_LAST);
    assign w_start     = (r_state == ST_FULL) && replay_start;
    assign w_replay    = (r_state == ST_REPLAY);
    // The output register may take a new word when empty or being drained.
    assign w_out_ready = !r_skip_valid || skip_ready;
    assign w_xfer      = w_replay && r_skip_valid && skip_ready;
    assign w_xfer_last = w_xfer && (r_rd_cnt == c_LAST);
    // The prefetch slot can be refilled when empty or moving forward now.
    assign w_slot_free = !r_rd_valid || w_out_ready;
    // Word 0 is fetched on the start cycle itself so it reaches the output
    // register two cycles after replay_start.
    assign w_fetch     = !reset && (w_start ||
                         (w_replay && w_slot_free && (r_fetch_cnt < c_DEPTH_W)));
    assign w_fetch_addr = w_start ? '0 : r_fetch_cnt[ADDR_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Buffer storage (contents deliberately not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_cnt[ADDR_WIDTH-1:0]] <= pxl_in;
        end
        if (w_fetch) begin
            r_rd_data <= r_mem[w_fetch_addr];
        end
    end

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL:   if (w_wr_last)    w_state_next = ST_FULL;
            ST_FULL:   if (replay_start) w_state_next = ST_REPLAY;
            ST_REPLAY: if (w_xfer_last)  w_state_next = ST_FILL;
            default:                     w_state_next = ST_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // Main path: one-cycle forward, data holds across gaps
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pxl_main   <= '0;
            r_valid_main <= 1'b0;
        end else begin
            r_valid_main <= valid_in;
            if (valid_in) begin
                r_pxl_main <= pxl_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters, prefetch slot, skip output register, drop flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt     <= '0;
            r_fetch_cnt  <= '0;
            r_rd_cnt     <= '0;
            r_rd_valid   <= 1'b0;
            r_skip_data  <= '0;
            r_skip_valid <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end

            if (w_start) begin
                r_fetch_cnt <= (ADDR_WIDTH + 1)'(1);
                r_rd_cnt    <= '0;
            end else if (w_fetch) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end

            if (w_xfer) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end

            if (w_fetch) begin
                r_rd_valid <= 1'b1;
            end else if (w_replay && w_out_ready) begin
                r_rd_valid <= 1'b0;
            end

            if (w_replay && w_out_ready) begin
                r_skip_valid <= r_rd_valid;
                if (r_rd_valid) begin
                    r_skip_data <= r_rd_data;
                end
            end

            if (w_xfer_last) begin
                r_skip_valid <= 1'b0;
                r_rd_valid   <= 1'b0;
                r_wr_cnt     <= '0;
                r_fetch_cnt  <= '0;
                r_rd_cnt     <= '0;
            end

            if ((r_state != ST_FILL) && valid_in) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign pxl_out_main   = r_pxl_main;
    assign valid_out_main = r_valid_main;
    assign pxl_out_skip   = r_skip_data;
    assign valid_out_skip = r_skip_valid;
    assign buf_full       = (r_state == ST_FULL);
    assign drop           = r_drop;

endmodule
`default_nettype wire
